// File: rtl/conv_pkg.sv
// Shared configuration, derived widths and FSM encoding for the convolution core.
package conv_pkg;

    typedef struct packed {
        int data_width;
        int fm_width;
        int fm_height;
        int in_ch;
        int out_ch;
        int kernel_size;
        int frac_bits;
    } config_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Index width for a 0..n-1 counter; never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_w(input config_t c);
        return 2 * c.data_width + $clog2(c.kernel_size * c.kernel_size * c.in_ch);
    endfunction

    localparam config_t DEFAULT_CFG = '{16, 128, 128, 2, 16, 3, 8};
    localparam int ACC_WIDTH = acc_w(DEFAULT_CFG);
    localparam int X_W       = idx_w(DEFAULT_CFG.fm_width);
    localparam int Y_W       = idx_w(DEFAULT_CFG.fm_height);
    localparam int CH_W      = idx_w(DEFAULT_CFG.out_ch);

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with arithmetic rescale and saturation.
// result reflects the accumulator including the current cycle's product.
module conv_mac #(
    parameter int DW   = 16,
    parameter int AW   = 36,
    parameter int FRAC = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 clear,
    input  logic                 en,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] result
);

    localparam logic signed [AW-1:0] MAX_V = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_next;
    logic signed [AW-1:0]   scaled;

    assign prod     = a * b;
    assign acc_next = en ? acc + AW'(prod) : acc;
    assign scaled   = acc_next >>> FRAC;

    always_comb begin
        result = scaled[DW-1:0];
        if (scaled > MAX_V) begin
            result = MAX_V[DW-1:0];
        end else if (scaled < MIN_V) begin
            result = MIN_V[DW-1:0];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/modport_conv_core.sv
// Streaming KxK "same" convolution: walks y,x,ch,ky,kx,inch and pulls one
// a/b word pair per in-bounds tap; padding taps cost a cycle with no handshake.
module modport_conv_core
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH         = 16,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int INPUT_NB_CHANNELS  = 2,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int KERNEL_SIZE        = 3,
    parameter int FRAC_BITS          = 8,
    parameter int XW                 = idx_w(FEATURE_MAP_WIDTH),
    parameter int YW                 = idx_w(FEATURE_MAP_HEIGHT),
    parameter int CHW                = idx_w(OUTPUT_NB_CHANNELS)
) (
    input  logic                         clk,
    input  logic                         arst,
    input  logic                         start,
    output logic                         running,
    input  logic signed [DATA_WIDTH-1:0] a_input,
    input  logic                         a_valid,
    output logic                         a_ready,
    input  logic signed [DATA_WIDTH-1:0] b_input,
    input  logic                         b_valid,
    output logic                         b_ready,
    output logic signed [DATA_WIDTH-1:0] output_data,
    output logic                         output_valid,
    output logic [XW-1:0]                output_x,
    output logic [YW-1:0]                output_y,
    output logic [CHW-1:0]               output_ch
);

    localparam config_t CFG = '{DATA_WIDTH, FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT,
                                INPUT_NB_CHANNELS, OUTPUT_NB_CHANNELS,
                                KERNEL_SIZE, FRAC_BITS};
    localparam int AW   = acc_w(CFG);
    localparam int KW   = idx_w(CFG.kernel_size);
    localparam int IW   = idx_w(CFG.in_ch);
    localparam int SW   = ((XW > YW) ? XW : YW) + KW + 1;
    localparam int HALF = CFG.kernel_size / 2;

    state_t                  state;
    logic [YW-1:0]           y;
    logic [XW-1:0]           x;
    logic [CHW-1:0]          ch;
    logic [KW-1:0]           ky;
    logic [KW-1:0]           kx;
    logic [IW-1:0]           inch;
    logic [SW-1:0]           sx;
    logic [SW-1:0]           sy;
    logic                    in_bounds;
    logic                    fire;
    logic                    step;
    logic                    last_tap;
    logic                    last_pixel;
    logic signed [DATA_WIDTH-1:0] result;

    // Tap position offset by HALF so the bounds test stays unsigned.
    assign sx = SW'(x) + SW'(kx);
    assign sy = SW'(y) + SW'(ky);
    assign in_bounds = (sx >= SW'(HALF)) && (sx < SW'(CFG.fm_width + HALF)) &&
                       (sy >= SW'(HALF)) && (sy < SW'(CFG.fm_height + HALF));

    assign fire    = (state == FETCH) && in_bounds && a_valid && b_valid;
    assign step    = (state == FETCH) && (!in_bounds || fire);
    assign a_ready = fire;
    assign b_ready = fire;

    assign last_tap = (inch == IW'(CFG.in_ch - 1)) &&
                      (kx == KW'(CFG.kernel_size - 1)) &&
                      (ky == KW'(CFG.kernel_size - 1));
    assign last_pixel = (ch == CHW'(CFG.out_ch - 1)) &&
                        (x == XW'(CFG.fm_width - 1)) &&
                        (y == YW'(CFG.fm_height - 1));

    conv_mac #(
        .DW   (DATA_WIDTH),
        .AW   (AW),
        .FRAC (CFG.frac_bits)
    ) u_mac (
        .clk    (clk),
        .arst   (arst),
        .clear  ((state != FETCH) || (step && last_tap)),
        .en     (fire),
        .a      (a_input),
        .b      (b_input),
        .result (result)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= IDLE;
            running      <= 1'b0;
            y            <= '0;
            x            <= '0;
            ch           <= '0;
            ky           <= '0;
            kx           <= '0;
            inch         <= '0;
            output_data  <= '0;
            output_valid <= 1'b0;
            output_x     <= '0;
            output_y     <= '0;
            output_ch    <= '0;
        end else begin
            output_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        running <= 1'b1;
                        y       <= '0;
                        x       <= '0;
                        ch      <= '0;
                        ky      <= '0;
                        kx      <= '0;
                        inch    <= '0;
                    end
                end
                FETCH: begin
                    if (step) begin
                        if (inch != IW'(CFG.in_ch - 1)) begin
                            inch <= inch + 1'b1;
                        end else begin
                            inch <= '0;
                            if (kx != KW'(CFG.kernel_size - 1)) begin
                                kx <= kx + 1'b1;
                            end else begin
                                kx <= '0;
                                if (ky != KW'(CFG.kernel_size - 1)) begin
                                    ky <= ky + 1'b1;
                                end else begin
                                    ky <= '0;
                                end
                            end
                        end
                        if (last_tap) begin
                            state        <= EMIT;
                            output_valid <= 1'b1;
                            output_data  <= result;
                            output_x     <= x;
                            output_y     <= y;
                            output_ch    <= ch;
                        end
                    end
                end
                EMIT: begin
                    if (last_pixel) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else begin
                        state <= FETCH;
                        if (ch != CHW'(CFG.out_ch - 1)) begin
                            ch <= ch + 1'b1;
                        end else begin
                            ch <= '0;
                            if (x != XW'(CFG.fm_width - 1)) begin
                                x <= x + 1'b1;
                            end else begin
                                x <= '0;
                                y <= y + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_modport_conv_core.sv
// Bench for modport_conv_core: three small configurations against a direct convolution model.
module tb_modport_conv_core;

    typedef struct {
        int x;
        int y;
        int ch;
        int val;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic        av = 1'b0;
    logic        bv = 1'b0;
    logic [15:0] ad = '0;
    logic [15:0] bd = '0;
    int          sel = 0;

    always #5 clk = ~clk;

    logic        run0, ar0, br0, ov0;
    logic [15:0] od0;
    logic [1:0]  ox0, oy0;
    logic [0:0]  och0;
    logic        run1, ar1, br1, ov1;
    logic [7:0]  od1;
    logic [1:0]  ox1, oy1;
    logic [0:0]  och1;
    logic        run2, ar2, br2, ov2;
    logic [15:0] od2;
    logic [1:0]  ox2, oy2;
    logic [0:0]  och2;

    modport_conv_core #(
        .DATA_WIDTH(16), .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
        .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(3), .FRAC_BITS(0)
    ) u0 (
        .clk(clk), .arst(arst), .start(start && (sel == 0)), .running(run0),
        .a_input(ad), .a_valid(av && (sel == 0)), .a_ready(ar0),
        .b_input(bd), .b_valid(bv && (sel == 0)), .b_ready(br0),
        .output_data(od0), .output_valid(ov0),
        .output_x(ox0), .output_y(oy0), .output_ch(och0)
    );

    modport_conv_core #(
        .DATA_WIDTH(8), .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
        .INPUT_NB_CHANNELS(1), .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(3), .FRAC_BITS(0)
    ) u1 (
        .clk(clk), .arst(arst), .start(start && (sel == 1)), .running(run1),
        .a_input(ad[7:0]), .a_valid(av && (sel == 1)), .a_ready(ar1),
        .b_input(bd[7:0]), .b_valid(bv && (sel == 1)), .b_ready(br1),
        .output_data(od1), .output_valid(ov1),
        .output_x(ox1), .output_y(oy1), .output_ch(och1)
    );

    modport_conv_core #(
        .DATA_WIDTH(16), .FEATURE_MAP_WIDTH(4), .FEATURE_MAP_HEIGHT(4),
        .INPUT_NB_CHANNELS(2), .OUTPUT_NB_CHANNELS(2), .KERNEL_SIZE(3), .FRAC_BITS(0)
    ) u2 (
        .clk(clk), .arst(arst), .start(start && (sel == 2)), .running(run2),
        .a_input(ad), .a_valid(av && (sel == 2)), .a_ready(ar2),
        .b_input(bd), .b_valid(bv && (sel == 2)), .b_ready(br2),
        .output_data(od2), .output_valid(ov2),
        .output_x(ox2), .output_y(oy2), .output_ch(och2)
    );

    logic [31:0] run, ard, brd, ov, od, ox, oy, och;

    always_comb begin
        run = '0; ard = '0; brd = '0; ov = '0;
        od = '0; ox = '0; oy = '0; och = '0;
        case (sel)
            0: begin
                run = 32'(run0); ard = 32'(ar0); brd = 32'(br0); ov = 32'(ov0);
                od = 32'($signed(od0)); ox = 32'(ox0); oy = 32'(oy0); och = 32'(och0);
            end
            1: begin
                run = 32'(run1); ard = 32'(ar1); brd = 32'(br1); ov = 32'(ov1);
                od = 32'($signed(od1)); ox = 32'(ox1); oy = 32'(oy1); och = 32'(och1);
            end
            default: begin
                run = 32'(run2); ard = 32'(ar2); brd = 32'(br2); ov = 32'(ov2);
                od = 32'($signed(od2)); ox = 32'(ox2); oy = 32'(oy2); och = 32'(och2);
            end
        endcase
    end

    int   ncmp = 0;
    int   nerr = 0;
    int   n_in, n_out, dw;
    int   img [2][4][4];
    int   ker [2][2][3][3];
    int   res [4][4][2];
    int   res_ref [4][4][2];
    int   aq [$];
    int   bq [$];
    exp_t eq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int sat(input int v, input int w);
        int hi, lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Direct convolution; also lays out both producer streams in consumption order.
    task automatic build();
        int sum, ix, iy;
        aq.delete(); bq.delete(); eq.delete();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                for (int c = 0; c < n_out; c++) begin
                    sum = 0;
                    for (int ky = 0; ky < 3; ky++)
                        for (int kx = 0; kx < 3; kx++)
                            for (int i = 0; i < n_in; i++) begin
                                iy = y + ky - 1;
                                ix = x + kx - 1;
                                if (ix >= 0 && ix < 4 && iy >= 0 && iy < 4) begin
                                    sum += img[i][iy][ix] * ker[c][i][ky][kx];
                                    aq.push_back(img[i][iy][ix]);
                                    bq.push_back(ker[c][i][ky][kx]);
                                end
                            end
                    eq.push_back('{x, y, c, sat(sum, dw)});
                end
    endtask

    task automatic run_layer(input int mode, input int restart_at);
        int   nout, nhs, total, nexp;
        bit   done;
        exp_t e;
        nout = 0; nhs = 0; done = 0;
        total = aq.size();
        nexp = eq.size();
        @(negedge clk);
        chk("idle_running", run, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("running_after_start", run, 1);
        for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
            if (ov === 32'd1) begin
                if (eq.size() > 0) begin
                    e = eq.pop_front();
                    chk("out_x", ox, e.x);
                    chk("out_y", oy, e.y);
                    chk("out_ch", och, e.ch);
                    chk("out_data", od, e.val);
                    res[e.y][e.x][e.ch] = int'(od);
                end else begin
                    chk("extra_output", 1, 0);
                end
                nout++;
            end
            if (eq.size() == 0 && run === 32'd0) begin
                done = 1;
            end else begin
                start = (cyc == restart_at);
                if (mode == 1) begin
                    av = 1'($urandom_range(0, 1));
                    bv = !(cyc >= 20 && cyc < 25);
                end else begin
                    av = 1'b1;
                    bv = 1'b1;
                end
                if (aq.size() == 0) av = 1'b0;
                if (bq.size() == 0) bv = 1'b0;
                ad = (aq.size() > 0) ? 16'(aq[0]) : 16'h0;
                bd = (bq.size() > 0) ? 16'(bq[0]) : 16'h0;
                #1;
                chk("ready_without_valid", 32'((ard[0] | brd[0]) & ~(av & bv)), 0);
                chk("ready_pair", ard, brd);
                if (ard === 32'd1) begin
                    void'(aq.pop_front());
                    void'(bq.pop_front());
                    nhs++;
                end
                @(negedge clk);
            end
        end
        start = 1'b0; av = 1'b0; bv = 1'b0;
        chk("layer_done", 32'(done), 1);
        chk("output_count", nout, nexp);
        chk("handshakes", nhs, total);
    endtask

    task automatic fill(input int imode, input int kmode);
        for (int i = 0; i < 2; i++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 4; x++)
                    case (imode)
                        0: img[i][y][x] = 1;
                        1: img[i][y][x] = y * 4 + x;
                        2: img[i][y][x] = 127;
                        default: img[i][y][x] = $urandom_range(0, 80) - 40;
                    endcase
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 2; i++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        case (kmode)
                            0: ker[c][i][ky][kx] = 1;
                            1: ker[c][i][ky][kx] = (ky == 1 && kx == 1) ? 1 : 0;
                            2: ker[c][i][ky][kx] = 127;
                            3: ker[c][i][ky][kx] = -127;
                            4: ker[c][i][ky][kx] = c + 1;
                            default: ker[c][i][ky][kx] = $urandom_range(0, 80) - 40;
                        endcase
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_running", run, 0);
            chk("rst_valid", ov, 0);
            chk("rst_data", od, 0);
            chk("rst_x", ox, 0);
            chk("rst_y", oy, 0);
            chk("rst_ch", och, 0);
            chk("rst_ready", ard, 0);
        end
        arst = 1'b0;

        sel = 0; n_in = 1; n_out = 1; dw = 16;
        fill(0, 0); build(); run_layer(0, -1);
        chk("ones_corner", res[0][0][0], 4);
        chk("ones_edge", res[0][1][0], 6);
        chk("ones_interior", res[1][1][0], 9);
        chk("ones_corner_far", res[3][3][0], 4);

        fill(1, 1); build(); run_layer(0, -1);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                chk("identity", res[y][x][0], y * 4 + x);

        fill(3, 5); build(); run_layer(0, -1);
        res_ref = res;
        build(); run_layer(1, -1);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                chk("stall_vs_unstalled", res[y][x][0], res_ref[y][x][0]);

        sel = 1; dw = 8;
        fill(2, 2); build(); run_layer(0, -1);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                chk("sat_pos", res[y][x][0], 127);
        fill(2, 3); build(); run_layer(0, -1);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                chk("sat_neg", res[y][x][0], -128);

        sel = 0; dw = 16;
        fill(0, 0); build(); run_layer(0, 50);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
            av = 1'b1; bv = 1'b1; ad = 16'd1; bd = 16'd1;
            @(negedge clk);
            if (ov === 32'd1) seen = 1;
        end
        chk("abort_reached_output", 32'(seen), 1);
        arst = 1'b1;
        @(negedge clk);
        chk("abort_running", run, 0);
        chk("abort_valid", ov, 0);
        chk("abort_ready", ard, 0);
        arst = 1'b0; av = 1'b0; bv = 1'b0;
        build(); run_layer(0, -1);
        chk("fresh_interior", res[2][2][0], 9);

        sel = 2; n_in = 2; n_out = 2;
        fill(0, 4); build(); run_layer(0, -1);
        chk("mc_interior_ch0", res[1][1][0], 18);
        chk("mc_interior_ch1", res[1][1][1], 36);
        chk("mc_corner_ch1", res[0][0][1], 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
